wb_arbiter: RTL
===============

# wb_arbiter

Writeback arbiter that merges the in-order pipeline writeback stream and the multi-cycle multiplier/divider result stream onto the single register-file write port. It sits directly upstream of the register file: its registered outputs drive `ctrl_writeEnable`, `ctrl_writeReg` and `data_writeReg`. The block holds one pending multdiv result and uses an age counter to force a pipeline bubble so that result cannot starve.

## Interface
Parameters:
- `MAX_WAIT`, default 4: number of held cycles after which `stall_req` asserts; legal range 1..15.

Ports:
- `clock`  in  1  system clock; all state updates on the posedge.
- `ctrl_reset`  in  1  reset; **synchronous, active-high**.
- `pipe_valid`  in  1  pipeline WB stage has a write this cycle; cannot be back-pressured.
- `pipe_rd`  in  5  pipeline destination register.
- `pipe_data`  in  32  pipeline write data.
- `md_valid`  in  1  multdiv result is valid.
- `md_rd`  in  5  multdiv destination register.
- `md_data`  in  32  multdiv result.
- `md_ready`  out  1  arbiter can accept a multdiv result; equals `!pend_valid && !ctrl_reset`.
- `ctrl_writeEnable`  out  1  registered write enable to the register file.
- `ctrl_writeReg`  out  5  registered write address.
- `data_writeReg`  out  32  registered write data.
- `md_pend_valid`  out  1  a multdiv result is held, for the hazard unit.
- `md_pend_rd`  out  5  destination of the held result.
- `stall_req`  out  1  request to the pipeline to insert a WB bubble next cycle.

## Operation
- Internal state: `pend_valid`, `pend_rd[4:0]`, `pend_data[31:0]`, `wait_cnt[3:0]`, and the three output registers.
- Definitions: P = `pipe_valid && pipe_rd!=0`; A = `md_valid && md_ready`; M = `A && md_rd!=0`.
- Writes to r0 are dropped. An accepted multdiv result with `md_rd==0` is consumed and discarded.
- Output register priority at each edge (first match wins):
  1. P: the pipeline write is emitted.
  2. `pend_valid`: the pending entry is emitted and `pend_valid` clears.
  3. M: the multdiv result is emitted directly (bypass; it never enters the buffer).
  4. Otherwise `ctrl_writeEnable` goes to 0 and the address/data outputs hold their values.
- Buffer capture: if M and P are both true in the same cycle and `md_rd != pipe_rd`, the multdiv result goes into the pending entry and `wait_cnt` is set to 0.
- WAW kill: a pipeline write is always treated as younger than any multdiv result.
  - If P and `pend_valid` and `pend_rd==pipe_rd`, the pending entry is cleared without being written.
  - If P and M and `md_rd==pipe_rd`, the multdiv result is discarded.
- Age counter:
  - While `pend_valid` stays set through an edge without being emitted, `wait_cnt` increments, saturating at `MAX_WAIT`.
  - It clears whenever `pend_valid` clears.
- `stall_req = pend_valid && wait_cnt==MAX_WAIT`, combinational from state.
  - The pipeline must hold `pipe_valid` at 0 in the following cycle.
  - If the pipeline violates this, priority rule 1 still applies and the entry keeps waiting. No error is flagged.
- Because `md_ready` is 0 while an entry is held, the single entry can never be overwritten.

## Timing
- Latency: an input accepted at edge N appears on the `ctrl_*`/`data_writeReg` outputs after edge N. The register file then commits it at edge N+1.
- A held multdiv result is emitted at the first edge with P false, so its minimum added latency is 1 cycle.
- `md_pend_valid` and `md_pend_rd` reflect state directly. `md_ready` rises in the cycle after the entry drains or is killed.
- Reset: when `ctrl_reset` is sampled high at an edge, all of the following go to 0:
  - `ctrl_writeEnable`, `ctrl_writeReg`, `data_writeReg`
  - `pend_valid`, `pend_rd`, `pend_data`, `wait_cnt`

  As a result, `stall_req` and `md_pend_valid` read 0.
- `md_ready` is 0 while `ctrl_reset` is high. A pending result present when reset asserts is lost; this is intentional, and the multdiv unit is reset by the same signal.
- Throughput: one register-file write per cycle. Sustained P keeps a held entry waiting until `stall_req` forces a gap.

## Test plan
- Reset, then `pipe_valid`=1, `pipe_rd`=5, `pipe_data`=0x1234 for one cycle -> next cycle `ctrl_writeEnable`=1, `ctrl_writeReg`=5, `data_writeReg`=0x1234; register file r5 reads 0x1234 after the following edge.
- `md_valid`=1, `md_rd`=7, `md_data`=0xDEADBEEF with `pipe_valid`=0 -> next cycle writes r7=0xDEADBEEF; `md_pend_valid` stays 0.
- Same cycle: pipe r3=0x11 and md r9=0x22 -> cycle+1 writes r3 with `md_pend_valid`=1, `md_pend_rd`=9, `md_ready`=0; cycle+2 (pipe idle) writes r9=0x22.
- Hold md r9; drive pipe writes to r1,r2,r3,r4 back-to-back with `MAX_WAIT`=4 -> `stall_req`=1 after the 4th held edge; drop `pipe_valid` -> r9 written next cycle and `stall_req` returns to 0.
- Hold md r6=0xAA, then pipe writes r6=0xBB -> r6 written once with 0xBB, `md_pend_valid` clears, and 0xAA is never written.
- Pipe write to r0 and md result to r0 -> `ctrl_writeEnable` stays 0 and `md_ready` stays 1. Assert `ctrl_reset` while an entry is held -> every output is 0 after the edge.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the in-order pipeline writeback stream and the
// multdiv result stream onto the single register-file write port. One multdiv
// result can be parked while the pipeline owns the port. An age counter raises
// stall_req so the parked result cannot starve.
module wb_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    input  logic        md_valid,
    input  logic [4:0]  md_rd,
    input  logic [31:0] md_data,
    output logic        md_ready,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [31:0] data_writeReg,
    output logic        md_pend_valid,
    output logic [4:0]  md_pend_rd,
    output logic        stall_req
);

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    logic        pend_valid;
    logic [4:0]  pend_rd;
    logic [31:0] pend_data;
    logic [3:0]  wait_cnt;

    logic        pipe_wr;
    logic        md_take;
    logic        md_wr;
    logic        pend_kill;
    logic        pend_emit;
    logic        pend_capture;

    // The single entry can never be overwritten because acceptance requires it empty.
    assign md_ready      = !pend_valid && !ctrl_reset;
    assign md_pend_valid = pend_valid;
    assign md_pend_rd    = pend_rd;
    assign stall_req     = pend_valid && (wait_cnt == WAIT_MAX);

    // Qualify requests; r0 writes are dropped, pipeline writes count as youngest.
    always_comb begin
        pipe_wr      = pipe_valid && (pipe_rd != 5'd0);
        md_take      = md_valid && md_ready;
        md_wr        = md_take && (md_rd != 5'd0);
        pend_kill    = pend_valid && pipe_wr && (pend_rd == pipe_rd);
        pend_emit    = pend_valid && !pipe_wr;
        pend_capture = md_wr && pipe_wr && (md_rd != pipe_rd);
    end

    // Output register: pipeline first, then the held entry, then a multdiv bypass.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            ctrl_writeEnable <= 1'b0;
            ctrl_writeReg    <= 5'd0;
            data_writeReg    <= 32'd0;
        end else if (pipe_wr) begin
            ctrl_writeEnable <= 1'b1;
            ctrl_writeReg    <= pipe_rd;
            data_writeReg    <= pipe_data;
        end else if (pend_valid) begin
            ctrl_writeEnable <= 1'b1;
            ctrl_writeReg    <= pend_rd;
            data_writeReg    <= pend_data;
        end else if (md_wr) begin
            ctrl_writeEnable <= 1'b1;
            ctrl_writeReg    <= md_rd;
            data_writeReg    <= md_data;
        end else begin
            ctrl_writeEnable <= 1'b0;
        end
    end

    // Pending entry and its age; a same-address pipeline write kills the entry.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            pend_valid <= 1'b0;
            pend_rd    <= 5'd0;
            pend_data  <= 32'd0;
            wait_cnt   <= 4'd0;
        end else if (pend_emit || pend_kill) begin
            pend_valid <= 1'b0;
            wait_cnt   <= 4'd0;
        end else if (pend_capture) begin
            pend_valid <= 1'b1;
            pend_rd    <= md_rd;
            pend_data  <= md_data;
            wait_cnt   <= 4'd0;
        end else if (pend_valid && (wait_cnt != WAIT_MAX)) begin
            wait_cnt   <= wait_cnt + 4'd1;
        end
    end

endmodule
